fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory (imem) in the ARM core.
- Owns the program counter and drives the imem word address.
- Captures the imem combinational read data into a small prefetch FIFO.
- Presents {pc, instr, pc+8} to decode over a valid/ready handshake, with branch redirect and flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] ignored (forced 0).
- DEPTH, 2, prefetch FIFO entries; legal range 2..8.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_a  out  32  word address to imem; always equals the internal fetch_pc.
- imem_rd  in  32  instruction word returned combinationally by imem for imem_a.
- redirect_valid  in  1  branch/exception redirect request.
- redirect_pc  in  32  redirect target; bits [1:0] forced 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  32  address of out_instr.
- out_pc_plus8  out  32  out_pc + 8, the ARM read value of R15.
- halted  out  1  halt detected; present only with FETCH_HALT_EN (see below).

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC & ~3; FIFO count = 0; out_valid = 0.
  - out_instr, out_pc and out_pc_plus8 are 0 whenever out_valid = 0; imem_a = RESET_PC.
  - Reset mid-operation discards all FIFO contents immediately.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count < DEPTH | pop).
  - Full with a simultaneous pop still pushes; count is unchanged.
- On push: the entry {fetch_pc, imem_rd} is written at the tail and fetch_pc <= fetch_pc + 4.
  - Wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- On redirect_valid (highest priority):
  - FIFO flushed (count <= 0); any same-cycle pop is still treated as accepted by decode, but the head is dropped by the flush.
  - fetch_pc <= redirect_pc & ~3; no push that cycle.
- Latency:
  - An instruction appears at out_valid the cycle after the edge that pushed it.
  - After reset release, out_valid = 1 following the first clock edge.
  - A redirect at edge N gives the target instruction at the output after edge N+1.
- Output is registered FIFO state only; there is no combinational path from imem_rd or redirect to out_*.
- Empty: out_valid = 0, and out_ready is ignored.
- Full, no pop: fetch_pc holds and imem_a is stable.
- count is ceil(log2(DEPTH+1)) bits wide; head and tail pointers wrap modulo DEPTH.
- No range check: imem handles addresses beyond its 256 words.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - A pushed instruction equal to the package constant HALT_INSTR (32'hEAFFFFFE, branch-to-self) sets a sticky halted flag.
  - While halted = 1, push is inhibited; the FIFO drains normally.
  - redirect_valid clears halted; reset clears it to 0.
- Not defined:
  - No halted port, and push never inhibited by instruction content.

Decomposition:
- Package fetch_pkg:
  - HALT_INSTR constant.
  - PC_STEP = 4 and PC_READ_OFFSET = 8.
  - Typedef fetch_entry_t = packed struct {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo, parameterised by DEPTH, storing fetch_entry_t.
  - Ports: clk, reset, flush, push, pop, din, dout, count, empty, full.
- fetch_stage holds fetch_pc, the push/redirect logic and the halt flag.

Test Plan:
- Reset with RESET_PC=0, out_ready=1, imem preloaded with words 0..7:
  - out_pc sequence 0,4,8,… one per cycle, out_instr = RAM[n], out_pc_plus8 = out_pc + 8.
- out_ready=0 for 5 cycles:
  - count saturates at DEPTH=2 and imem_a holds at 8.
  - Release gives pcs 0,4,8 with no loss or duplication.
- Redirect to 32'h0000_0043 while the FIFO is full and out_ready=1:
  - out_valid=0 the next cycle, then out_pc = 32'h40 with instr = RAM[16].
- Force fetch_pc to 32'hFFFF_FFFC via redirect:
  - Next pushed pc is 32'h0000_0000, and out_pc_plus8 for FFFF_FFFC equals 32'h0000_0004.
- Assert reset asynchronously mid-stream, between edges:
  - out_valid drops to 0 immediately and imem_a = RESET_PC.
  - After release, fetch resumes from RESET_PC.
- FETCH_HALT_EN defined, RAM[3]=32'hEAFFFFFE:
  - halted=1 after pc 12 is pushed and no pc 16 is issued.
  - Redirect to 0 clears halted and refetch begins at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Consumed by fetch_fifo and fetch_stage.
package fetch_pkg;

  localparam logic [31:0] HALT_INSTR     = 32'hEAFF_FFFE;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between imem and decode.
// Flush empties it in one cycle; a full FIFO accepts a push when it also pops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          pop_eff;
  logic          push_eff;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign dout     = mem[head];

  // Storage carries no reset; the top masks dout whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_eff) begin
        head <= next_ptr(head);
      end
      if (push_eff) begin
        tail <= next_ptr(tail);
      end
      if (push_eff && !pop_eff) begin
        count <= count + CW'(1);
      end else if (pop_eff && !push_eff) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns fetch_pc, drives imem, and feeds decode via a prefetch FIFO.
// Optional halt-on-branch-to-self detection is enabled by defining FETCH_HALT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_HALT_EN
  output logic        halted,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus8
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic          pop;
  logic          push;
  logic          halt_block;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count_unused;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_dout;

  assign imem_a    = fetch_pc;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ~halt_block & (~fifo_full | pop);
  assign fifo_din  = '{pc: fetch_pc, instr: imem_rd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC_ALIGNED;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

`ifdef FETCH_HALT_EN
  // Sticky until a redirect; the FIFO keeps draining while fetch is stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= 1'b0;
    end else if (push && (imem_rd == HALT_INSTR)) begin
      halted <= 1'b1;
    end
  end

  assign halt_block = halted;
`else
  assign halt_block = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count_unused),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outputs read as zero while nothing valid sits at the head.
  always_comb begin
    out_instr    = '0;
    out_pc       = '0;
    out_pc_plus8 = '0;
    if (out_valid) begin
      out_instr    = fifo_dout.instr;
      out_pc       = fifo_dout.pc;
      out_pc_plus8 = fifo_dout.pc + PC_READ_OFFSET;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 256-word combinational imem model.
// Halt-flag checks are included when FETCH_HALT_EN is defined.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif

  logic [31:0] ram [256];
  int testsRun  = 0;
  int failCount = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_HALT_EN
    .halted         (halted),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus8   (out_pc_plus8)
  );

  always #5 clk = ~clk;

  assign imem_rd = ram[imem_a[9:2]];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  // Reset asserted across one edge, released between edges.
  task automatic applyReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1100_0000 + i;

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_imem_a", imem_a, 32'h0);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_instr", out_instr, 32'h0);
    checkOutput("rst_pc8", out_pc_plus8, 32'h0);

    // Streaming with out_ready held high
    reset = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stream_pc", out_pc, 32'(4 * k));
      checkOutput("stream_instr", out_instr, 32'h1100_0000 + 32'(k));
      checkOutput("stream_pc8", out_pc_plus8, 32'(4 * k + 8));
      tick();
    end

    // Back-pressure: FIFO fills to two entries and fetch stalls at 8
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyReset();
    tick();
    tick();
    checkOutput("stall_imem_a_2", imem_a, 32'h8);
    tick();
    tick();
    tick();
    checkOutput("stall_imem_a_5", imem_a, 32'h8);
    checkOutput("stall_pc", out_pc, 32'h0);
    checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_pc", out_pc, 32'(4 * k));
      checkOutput("drain_instr", out_instr, 32'h1100_0000 + 32'(k));
      tick();
    end

    // Redirect while full and draining
    applyStimulus(1'b1, 32'h0000_0043, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("redir_imem_a", imem_a, 32'h40);
    checkOutput("redir_instr_zero", out_instr, 32'h0);
    tick();
    checkOutput("redir_tgt_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("redir_tgt_pc", out_pc, 32'h40);
    checkOutput("redir_tgt_instr", out_instr, 32'h1100_0010);
    checkOutput("redir_tgt_pc8", out_pc_plus8, 32'h48);

    // Address wrap at the top of the 32-bit space
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_imem_a", imem_a, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc8", out_pc_plus8, 32'h0000_0004);
    checkOutput("wrap_instr", out_instr, 32'h1100_00FF);
    checkOutput("wrap_imem_a_next", imem_a, 32'h0);
    tick();
    checkOutput("wrap_next_pc", out_pc, 32'h0);
    checkOutput("wrap_next_instr", out_instr, 32'h1100_0000);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_imem_a", imem_a, 32'h0);
    checkOutput("async_pc", out_pc, 32'h0);
    #1;
    reset = 1'b1;
    tick();
    checkOutput("resume_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("resume_pc", out_pc, 32'h0);
    tick();
    checkOutput("resume_pc_next", out_pc, 32'h4);

`ifdef FETCH_HALT_EN
    // Branch-to-self at pc 12 stops fetch until a redirect
    ram[3] = HALT_INSTR;
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyReset();
    tick();
    tick();
    tick();
    checkOutput("halt_pre", {31'b0, halted}, 32'd0);
    tick();
    checkOutput("halt_set", {31'b0, halted}, 32'd1);
    checkOutput("halt_head_pc", out_pc, 32'hC);
    tick();
    checkOutput("halt_drained", {31'b0, out_valid}, 32'd0);
    checkOutput("halt_imem_a", imem_a, 32'h10);
    tick();
    checkOutput("halt_hold", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("halt_clear", {31'b0, halted}, 32'd0);
    tick();
    checkOutput("halt_refetch_pc", out_pc, 32'h0);
    checkOutput("halt_refetch_valid", {31'b0, out_valid}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
